// File: rtl/axi4lite_master_if.sv
// AXI4-Lite master bridging level-held core load/store requests to single-beat bus transactions.
// Optional sticky response-error flag: define AXI4LITE_RESP_ERR_EN to add the resp_err output.
`timescale 1ns/1ps

module axi4lite_master_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    // core-side store request
    input  logic                  write_start,
    input  logic [ADDR_W-1:0]     write_addr,
    input  logic [DATA_W-1:0]     write_data,
    input  logic [DATA_W/8-1:0]   write_strobe,
    output logic                  write_busy,
    // core-side load request
    input  logic                  read_start,
    input  logic [ADDR_W-1:0]     read_addr,
    output logic [DATA_W-1:0]     read_data,
    output logic                  read_busy,
`ifdef AXI4LITE_RESP_ERR_EN
    output logic                  resp_err,
`endif
    // AXI4-Lite master
    output logic [ADDR_W-1:0]     m_awaddr,
    output logic                  m_awvalid,
    input  logic                  m_awready,
    output logic [DATA_W-1:0]     m_wdata,
    output logic [DATA_W/8-1:0]   m_wstrb,
    output logic                  m_wvalid,
    input  logic                  m_wready,
    input  logic [1:0]            m_bresp,
    input  logic                  m_bvalid,
    output logic                  m_bready,
    output logic [ADDR_W-1:0]     m_araddr,
    output logic                  m_arvalid,
    input  logic                  m_arready,
    input  logic [DATA_W-1:0]     m_rdata,
    input  logic [1:0]            m_rresp,
    input  logic                  m_rvalid,
    output logic                  m_rready
);

    typedef enum logic [2:0] {
        IDLE,
        WR_ADDR_DATA,
        WR_RESP,
        RD_ADDR,
        RD_DATA,
        DONE
    } state_t;

    state_t                r_state;
    logic [ADDR_W-1:0]     r_awaddr;
    logic [DATA_W-1:0]     r_wdata;
    logic [DATA_W/8-1:0]   r_wstrb;
    logic [ADDR_W-1:0]     r_araddr;
    logic [DATA_W-1:0]     r_read_data;
    logic                  r_awvalid;
    logic                  r_wvalid;
    logic                  r_bready;
    logic                  r_arvalid;
    logic                  r_rready;
    logic                  r_aw_done;
    logic                  r_w_done;
    logic                  r_resp_err;

    logic                  w_aw_hs;
    logic                  w_w_hs;
    logic                  w_aw_complete;
    logic                  w_w_complete;

    assign w_aw_hs       = r_awvalid & m_awready;
    assign w_w_hs        = r_wvalid & m_wready;
    // A channel counts as finished if it completed earlier or is completing this cycle.
    assign w_aw_complete = r_aw_done | w_aw_hs;
    assign w_w_complete  = r_w_done | w_w_hs;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_awaddr    <= '0;
            r_wdata     <= '0;
            r_wstrb     <= '0;
            r_araddr    <= '0;
            r_read_data <= '0;
            r_awvalid   <= 1'b0;
            r_wvalid    <= 1'b0;
            r_bready    <= 1'b0;
            r_arvalid   <= 1'b0;
            r_rready    <= 1'b0;
            r_aw_done   <= 1'b0;
            r_w_done    <= 1'b0;
            r_resp_err  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (write_start) begin
                        r_awaddr  <= write_addr;
                        r_wdata   <= write_data;
                        r_wstrb   <= write_strobe;
                        r_awvalid <= 1'b1;
                        r_wvalid  <= 1'b1;
                        r_aw_done <= 1'b0;
                        r_w_done  <= 1'b0;
                        r_state   <= WR_ADDR_DATA;
                    end else if (read_start) begin
                        r_araddr  <= read_addr;
                        r_arvalid <= 1'b1;
                        r_state   <= RD_ADDR;
                    end
                end
                WR_ADDR_DATA: begin
                    if (w_aw_hs) begin
                        r_awvalid <= 1'b0;
                        r_aw_done <= 1'b1;
                    end
                    if (w_w_hs) begin
                        r_wvalid <= 1'b0;
                        r_w_done <= 1'b1;
                    end
                    if (w_aw_complete && w_w_complete) begin
                        r_bready <= 1'b1;
                        r_state  <= WR_RESP;
                    end
                end
                WR_RESP: begin
                    if (m_bvalid) begin
                        r_bready <= 1'b0;
                        if (m_bresp != 2'b00) begin
                            r_resp_err <= 1'b1;
                        end
                        r_state <= DONE;
                    end
                end
                RD_ADDR: begin
                    if (m_arready) begin
                        r_arvalid <= 1'b0;
                        r_rready  <= 1'b1;
                        r_state   <= RD_DATA;
                    end
                end
                RD_DATA: begin
                    if (m_rvalid) begin
                        r_read_data <= m_rdata;
                        r_rready    <= 1'b0;
                        if (m_rresp != 2'b00) begin
                            r_resp_err <= 1'b1;
                        end
                        r_state <= DONE;
                    end
                end
                // Single-cycle gap with both busy flags low lets the core drop its start.
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign write_busy = ((r_state == IDLE) & write_start)
                      | (r_state == WR_ADDR_DATA)
                      | (r_state == WR_RESP);
    assign read_busy  = ((r_state == IDLE) & read_start & ~write_start)
                      | (r_state == RD_ADDR)
                      | (r_state == RD_DATA);

    assign read_data = r_read_data;
    assign m_awaddr  = r_awaddr;
    assign m_awvalid = r_awvalid;
    assign m_wdata   = r_wdata;
    assign m_wstrb   = r_wstrb;
    assign m_wvalid  = r_wvalid;
    assign m_bready  = r_bready;
    assign m_araddr  = r_araddr;
    assign m_arvalid = r_arvalid;
    assign m_rready  = r_rready;

`ifdef AXI4LITE_RESP_ERR_EN
    assign resp_err = r_resp_err;
`else
    logic w_unused_resp_err;
    assign w_unused_resp_err = r_resp_err;
`endif

endmodule

// File: tb/tb_axi4lite_master_if.sv
// Directed bench for axi4lite_master_if: cycle-exact stimulus with a bus monitor and scoreboard queues.
`timescale 1ns/1ps

module tb_axi4lite_master_if;

    logic        clk = 1'b0;
    logic        rst;
    logic        write_start;
    logic [31:0] write_addr;
    logic [31:0] write_data;
    logic [3:0]  write_strobe;
    logic        write_busy;
    logic        read_start;
    logic [31:0] read_addr;
    logic [31:0] read_data;
    logic        read_busy;
`ifdef AXI4LITE_RESP_ERR_EN
    logic        resp_err;
`endif
    logic [31:0] m_awaddr;
    logic        m_awvalid;
    logic        m_awready;
    logic [31:0] m_wdata;
    logic [3:0]  m_wstrb;
    logic        m_wvalid;
    logic        m_wready;
    logic [1:0]  m_bresp;
    logic        m_bvalid;
    logic        m_bready;
    logic [31:0] m_araddr;
    logic        m_arvalid;
    logic        m_arready;
    logic [31:0] m_rdata;
    logic [1:0]  m_rresp;
    logic        m_rvalid;
    logic        m_rready;

    int checks = 0;
    int errors = 0;
    int aw_cnt = 0;
    int w_cnt  = 0;
    int b_cnt  = 0;
    int ar_cnt = 0;
    int r_cnt  = 0;
    int aw0, b0, ar0, r0;

    logic [31:0] exp_aw[$];
    logic [31:0] exp_wdata[$];
    logic [31:0] exp_wstrb[$];
    logic [31:0] exp_ar[$];
    logic [31:0] exp_rd[$];

    always #5 clk = ~clk;

    axi4lite_master_if #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk),
        .rst(rst),
        .write_start(write_start),
        .write_addr(write_addr),
        .write_data(write_data),
        .write_strobe(write_strobe),
        .write_busy(write_busy),
        .read_start(read_start),
        .read_addr(read_addr),
        .read_data(read_data),
        .read_busy(read_busy),
`ifdef AXI4LITE_RESP_ERR_EN
        .resp_err(resp_err),
`endif
        .m_awaddr(m_awaddr),
        .m_awvalid(m_awvalid),
        .m_awready(m_awready),
        .m_wdata(m_wdata),
        .m_wstrb(m_wstrb),
        .m_wvalid(m_wvalid),
        .m_wready(m_wready),
        .m_bresp(m_bresp),
        .m_bvalid(m_bvalid),
        .m_bready(m_bready),
        .m_araddr(m_araddr),
        .m_arvalid(m_arvalid),
        .m_arready(m_arready),
        .m_rdata(m_rdata),
        .m_rresp(m_rresp),
        .m_rvalid(m_rvalid),
        .m_rready(m_rready)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Bus monitor: payload must match the queue head for every cycle its valid is high.
    always @(posedge clk) begin
        if (!rst) begin
            if (m_awvalid) begin
                if (exp_aw.size() == 0) chk("aw_unexpected", 32'(m_awvalid), 32'd0);
                else chk("awaddr", m_awaddr, exp_aw[0]);
                if (m_awready) begin
                    aw_cnt++;
                    if (exp_aw.size() != 0) void'(exp_aw.pop_front());
                end
            end
            if (m_wvalid) begin
                if (exp_wdata.size() == 0) chk("w_unexpected", 32'(m_wvalid), 32'd0);
                else begin
                    chk("wdata", m_wdata, exp_wdata[0]);
                    chk("wstrb", 32'(m_wstrb), exp_wstrb[0]);
                end
                if (m_wready) begin
                    w_cnt++;
                    if (exp_wdata.size() != 0) begin
                        void'(exp_wdata.pop_front());
                        void'(exp_wstrb.pop_front());
                    end
                end
            end
            if (m_arvalid) begin
                if (exp_ar.size() == 0) chk("ar_unexpected", 32'(m_arvalid), 32'd0);
                else chk("araddr", m_araddr, exp_ar[0]);
                if (m_arready) begin
                    ar_cnt++;
                    if (exp_ar.size() != 0) void'(exp_ar.pop_front());
                end
            end
            if (m_bvalid && m_bready) b_cnt++;
            if (m_rvalid && m_rready) r_cnt++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        write_start = 1'b0; write_addr = '0; write_data = '0; write_strobe = '0;
        read_start = 1'b0; read_addr = '0;
        m_awready = 1'b0; m_wready = 1'b0; m_bresp = 2'b00; m_bvalid = 1'b0;
        m_arready = 1'b0; m_rdata = '0; m_rresp = 2'b00; m_rvalid = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_write_busy", 32'(write_busy), 32'd0);
        chk("rst_read_busy",  32'(read_busy),  32'd0);
        chk("rst_awvalid",    32'(m_awvalid),  32'd0);
        chk("rst_wvalid",     32'(m_wvalid),   32'd0);
        chk("rst_bready",     32'(m_bready),   32'd0);
        chk("rst_arvalid",    32'(m_arvalid),  32'd0);
        chk("rst_rready",     32'(m_rready),   32'd0);
        chk("rst_read_data",  read_data,       32'd0);
`ifdef AXI4LITE_RESP_ERR_EN
        chk("rst_resp_err",   32'(resp_err),   32'd0);
`endif
        rst = 1'b0;

        // SW 0x10 = 0xCAFEBABE, zero-wait slave
        @(negedge clk);
        aw0 = aw_cnt; b0 = b_cnt;
        m_awready = 1'b1; m_wready = 1'b1; m_bvalid = 1'b1; m_bresp = 2'b00;
        write_addr = 32'h10; write_data = 32'hCAFEBABE; write_strobe = 4'b1111; write_start = 1'b1;
        exp_aw.push_back(32'h10); exp_wdata.push_back(32'hCAFEBABE); exp_wstrb.push_back(32'hF);
        #1;
        chk("sw_c0_busy",    32'(write_busy), 32'd1);
        chk("sw_c0_awvalid", 32'(m_awvalid),  32'd0);
        @(negedge clk);
        chk("sw_c1_awvalid", 32'(m_awvalid),  32'd1);
        chk("sw_c1_wvalid",  32'(m_wvalid),   32'd1);
        chk("sw_c1_busy",    32'(write_busy), 32'd1);
        @(negedge clk);
        chk("sw_c2_awvalid", 32'(m_awvalid),  32'd0);
        chk("sw_c2_wvalid",  32'(m_wvalid),   32'd0);
        chk("sw_c2_bready",  32'(m_bready),   32'd1);
        chk("sw_c2_busy",    32'(write_busy), 32'd1);
        @(negedge clk);
        chk("sw_c3_busy",    32'(write_busy), 32'd0);
        chk("sw_c3_bready",  32'(m_bready),   32'd0);
        write_start = 1'b0;
        @(negedge clk);
        chk("sw_aw_count",   32'(aw_cnt - aw0), 32'd1);
        chk("sw_b_count",    32'(b_cnt - b0),   32'd1);
        chk("sw_c4_busy",    32'(write_busy),   32'd0);

        // SB strobe 0100, awready delayed 3 cycles, wready immediate
        @(negedge clk);
        aw0 = aw_cnt; b0 = b_cnt;
        m_awready = 1'b0; m_wready = 1'b1; m_bvalid = 1'b1;
        write_addr = 32'h14; write_data = 32'h00AB0000; write_strobe = 4'b0100; write_start = 1'b1;
        exp_aw.push_back(32'h14); exp_wdata.push_back(32'h00AB0000); exp_wstrb.push_back(32'h4);
        #1;
        chk("sb_c0_busy",    32'(write_busy), 32'd1);
        @(negedge clk);
        chk("sb_c1_awvalid", 32'(m_awvalid),  32'd1);
        chk("sb_c1_wvalid",  32'(m_wvalid),   32'd1);
        @(negedge clk);
        chk("sb_c2_awvalid", 32'(m_awvalid),  32'd1);
        chk("sb_c2_wvalid",  32'(m_wvalid),   32'd0);
        chk("sb_c2_bready",  32'(m_bready),   32'd0);
        @(negedge clk);
        chk("sb_c3_awvalid", 32'(m_awvalid),  32'd1);
        chk("sb_c3_busy",    32'(write_busy), 32'd1);
        m_awready = 1'b1;
        @(negedge clk);
        chk("sb_c4_awvalid", 32'(m_awvalid),  32'd0);
        chk("sb_c4_bready",  32'(m_bready),   32'd1);
        chk("sb_c4_busy",    32'(write_busy), 32'd1);
        @(negedge clk);
        chk("sb_c5_busy",    32'(write_busy), 32'd0);
        write_start = 1'b0;
        @(negedge clk);
        chk("sb_aw_count",   32'(aw_cnt - aw0), 32'd1);
        chk("sb_b_count",    32'(b_cnt - b0),   32'd1);

        // LW 0x20, rvalid delayed 2 cycles, read_start held through DONE
        @(negedge clk);
        ar0 = ar_cnt; r0 = r_cnt;
        m_arready = 1'b1; m_rvalid = 1'b0; m_rdata = 32'h12345678; m_rresp = 2'b00;
        read_addr = 32'h20; read_start = 1'b1;
        exp_ar.push_back(32'h20); exp_rd.push_back(32'h12345678);
        #1;
        chk("lw_c0_rbusy",   32'(read_busy),  32'd1);
        chk("lw_c0_wbusy",   32'(write_busy), 32'd0);
        @(negedge clk);
        chk("lw_c1_arvalid", 32'(m_arvalid),  32'd1);
        chk("lw_c1_busy",    32'(read_busy),  32'd1);
        @(negedge clk);
        chk("lw_c2_arvalid", 32'(m_arvalid),  32'd0);
        chk("lw_c2_rready",  32'(m_rready),   32'd1);
        chk("lw_c2_busy",    32'(read_busy),  32'd1);
        @(negedge clk);
        chk("lw_c3_rready",  32'(m_rready),   32'd1);
        chk("lw_c3_rdata",   read_data,       32'd0);
        @(negedge clk);
        chk("lw_c4_busy",    32'(read_busy),  32'd1);
        m_rvalid = 1'b1;
        @(negedge clk);
        chk("lw_c5_busy",    32'(read_busy),  32'd0);
        chk("lw_c5_rdata",   read_data,       exp_rd.pop_front());
        read_start = 1'b0; m_rvalid = 1'b0;
        @(negedge clk);
        chk("lw_ar_count",   32'(ar_cnt - ar0), 32'd1);
        chk("lw_r_count",    32'(r_cnt - r0),   32'd1);
        chk("lw_hold_rdata", read_data,         32'h12345678);

        // Simultaneous write and read start: write wins, no AR
        @(negedge clk);
        aw0 = aw_cnt; ar0 = ar_cnt;
        m_awready = 1'b1; m_wready = 1'b1; m_bvalid = 1'b1;
        write_addr = 32'h30; write_data = 32'h5555AAAA; write_strobe = 4'b1111; write_start = 1'b1;
        read_addr = 32'h40; read_start = 1'b1;
        exp_aw.push_back(32'h30); exp_wdata.push_back(32'h5555AAAA); exp_wstrb.push_back(32'hF);
        #1;
        chk("both_c0_wbusy", 32'(write_busy), 32'd1);
        chk("both_c0_rbusy", 32'(read_busy),  32'd0);
        @(negedge clk);
        chk("both_c1_arvalid", 32'(m_arvalid), 32'd0);
        chk("both_c1_awvalid", 32'(m_awvalid), 32'd1);
        @(negedge clk);
        chk("both_c2_bready", 32'(m_bready),  32'd1);
        chk("both_c2_rbusy",  32'(read_busy), 32'd0);
        @(negedge clk);
        chk("both_c3_wbusy", 32'(write_busy), 32'd0);
        write_start = 1'b0; read_start = 1'b0;
        @(negedge clk);
        chk("both_aw_count", 32'(aw_cnt - aw0), 32'd1);
        chk("both_ar_count", 32'(ar_cnt - ar0), 32'd0);

        // Reset while RD_DATA waits, then a clean read
        @(negedge clk);
        ar0 = ar_cnt; r0 = r_cnt;
        m_arready = 1'b1; m_rvalid = 1'b0; m_rdata = 32'hDEAD0001;
        read_addr = 32'h44; read_start = 1'b1;
        exp_ar.push_back(32'h44);
        @(negedge clk);
        chk("rr_c1_arvalid", 32'(m_arvalid), 32'd1);
        @(negedge clk);
        chk("rr_c2_rready",  32'(m_rready),  32'd1);
        @(negedge clk);
        rst = 1'b1; read_start = 1'b0;
        #1;
        chk("rr_rst_rready",  32'(m_rready),  32'd0);
        chk("rr_rst_arvalid", 32'(m_arvalid), 32'd0);
        chk("rr_rst_rdata",   read_data,      32'd0);
        chk("rr_rst_rbusy",   32'(read_busy), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        m_rvalid = 1'b1; m_rdata = 32'hA5A50F0F;
        read_addr = 32'h48; read_start = 1'b1;
        exp_ar.push_back(32'h48); exp_rd.push_back(32'hA5A50F0F);
        #1;
        chk("rr2_c0_rbusy",  32'(read_busy), 32'd1);
        @(negedge clk);
        chk("rr2_c1_arvalid", 32'(m_arvalid), 32'd1);
        @(negedge clk);
        chk("rr2_c2_rready", 32'(m_rready),  32'd1);
        @(negedge clk);
        chk("rr2_c3_rbusy",  32'(read_busy), 32'd0);
        chk("rr2_c3_rdata",  read_data,      exp_rd.pop_front());
        read_start = 1'b0; m_rvalid = 1'b0;
        @(negedge clk);
        chk("rr_ar_count",   32'(ar_cnt - ar0), 32'd2);
        chk("rr_r_count",    32'(r_cnt - r0),   32'd1);

`ifdef AXI4LITE_RESP_ERR_EN
        // SLVERR on B sets sticky resp_err
        @(negedge clk);
        m_bresp = 2'b10; m_bvalid = 1'b1;
        write_addr = 32'h50; write_data = 32'h0000BEEF; write_strobe = 4'b0011; write_start = 1'b1;
        exp_aw.push_back(32'h50); exp_wdata.push_back(32'h0000BEEF); exp_wstrb.push_back(32'h3);
        repeat (3) @(negedge clk);
        write_start = 1'b0;
        chk("err_set", 32'(resp_err), 32'd1);
        @(negedge clk);
        m_bresp = 2'b00;
        write_addr = 32'h54; write_data = 32'h1; write_strobe = 4'b0001; write_start = 1'b1;
        exp_aw.push_back(32'h54); exp_wdata.push_back(32'h1); exp_wstrb.push_back(32'h1);
        repeat (3) @(negedge clk);
        write_start = 1'b0;
        chk("err_sticky", 32'(resp_err), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("err_rst", 32'(resp_err), 32'd0);
        @(negedge clk);
        rst = 1'b0;
`endif

        @(negedge clk);
        chk("sb_aw_empty", 32'(exp_aw.size()),    32'd0);
        chk("sb_w_empty",  32'(exp_wdata.size()), 32'd0);
        chk("sb_ar_empty", 32'(exp_ar.size()),    32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
